bit_serial_sub: RTL and testbench
=================================

// Module: bit_serial_sub
// PURPOSE
//  Bit-serial WIDTH-bit subtractor: diff = a - b, one full-subtractor bit per clock, LSB first.
//  A single registered borrow flop links successive bits.
//  Inverse datapath companion to the full-adder arithmetic blocks, for area-constrained sequential designs.
//  Operands are captured on a start pulse; done is pulsed when diff/borrow_out are valid.
// PARAMETERS
//  WIDTH   8   operand and result width in bits (>=1)
// PORTS
//  clk         in   1      single clock; all flops update on rising edge
//  rst         in   1      synchronous, active-high reset
//  start       in   1      request; sampled only in IDLE
//  a           in   WIDTH  minuend, captured when start is accepted
//  b           in   WIDTH  subtrahend, captured when start is accepted
//  busy        out  1      high while bits are being processed
//  done        out  1      one-cycle pulse: diff/borrow_out valid
//  diff        out  WIDTH  a - b modulo 2^WIDTH
//  borrow_out  out  1      1 when a < b (unsigned)
//  ovf         out  1      signed overflow (only with BSUB_OVF_EN)
// BEHAVIOUR
//  - Reset: state=IDLE; busy, done, diff, borrow_out, ovf, borrow flop, bit counter all 0. Operand shift regs 0.
//  - Reset mid-operation aborts the subtraction; no done pulse for the aborted request.
//  - FSM: IDLE -> SHIFT (start=1 at edge E0) -> DONE (after WIDTH bits) -> IDLE (next edge).
//  - Edge E0 (accept): load a_sr=a, b_sr=b, borrow=0, cnt=0, busy<=1; diff is not cleared yet.
//  - SHIFT, each edge: d = a_sr[0]^b_sr[0]^br; br' = (~a_sr[0]&b_sr[0]) | (~(a_sr[0]^b_sr[0])&br);
//    shift a_sr/b_sr right; shift d into MSB of result reg; cnt++.
//  - Result update: diff is written from the completed result reg at the last SHIFT edge.
//  - Latency: busy high for exactly WIDTH cycles after E0. Edge E0+WIDTH: state=DONE, busy<=0, done<=1.
//    At that same edge: diff = result, borrow_out = final br.
//  - done is high for exactly one cycle (DONE state).
//  - diff/borrow_out/ovf hold their values until the next accepted start completes.
//  - start while busy or in DONE: ignored, no queuing. Operand changes after E0 have no effect.
//  - start held high continuously: a new op is accepted on the first IDLE cycle.
//    Back-to-back throughput is one op per WIDTH+2 cycles.
//  - WIDTH=1: a single SHIFT cycle; done one cycle after busy.
//  - Counter width clog2(WIDTH+1); no wrap-around beyond WIDTH.
// CONFIGURATION
//  BSUB_OVF_EN defined:
//    - ovf port present, registered at the same edge as diff.
//    - ovf = (a[W-1]!=b[W-1]) & (diff[W-1]!=a[W-1]), using the captured operands; 0 on reset.
//  BSUB_OVF_EN undefined:
//    - ovf port and its logic are absent; all other behaviour is identical.
// TESTING (WIDTH=8)
//  1. a=5, b=3, start 1 cycle -> busy 8 cycles, then done=1 for 1 cycle, diff=0x02, borrow_out=0.
//  2. a=3, b=5 -> diff=0xFE, borrow_out=1; a=0, b=0 -> diff=0x00, borrow_out=0.
//  3. a=0x80, b=0x01 -> diff=0x7F, borrow_out=0, ovf=1 (BSUB_OVF_EN). a=0x7F, b=0x01 -> ovf=0.
//  4. Start a=9, b=4; at cycle 3 pulse start with a=1, b=2 -> single done, diff=0x05; second request lost.
//  5. Start a=0xFF, b=0x01; assert rst at cycle 4 -> next cycle busy=0, done never pulses, diff=0.
//     Then a=0x10, b=0x10 -> diff=0x00.
//  6. start held high with a=7, b=2 -> done pulses every 10 cycles, diff=0x05 each time.

Source files
------------

// File: rtl/bit_serial_sub.sv
// rtl/bit_serial_sub.sv - bit-serial LSB-first subtractor, optional signed overflow flag (BSUB_OVF_EN)
module bit_serial_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
`ifdef BSUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] a_sr, b_sr, res, res_next;
  logic [CW-1:0]    cnt;
  logic             br, br_next, bit_d, last_bit;
`ifdef BSUB_OVF_EN
  logic             a_msb, b_msb;
`endif

  // One full-subtractor slice on the current LSBs; result enters from the MSB end
  always_comb begin
    bit_d              = a_sr[0] ^ b_sr[0] ^ br;
    br_next            = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);
    res_next           = res >> 1;
    res_next[WIDTH-1]  = bit_d;
    last_bit           = (cnt == CW'(WIDTH - 1));
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state: accept in IDLE, walk WIDTH bits, one DONE cycle, back to IDLE
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (last_bit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: operand capture, serial shift, result publish on the final bit
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr       <= '0;
      b_sr       <= '0;
      res        <= '0;
      br         <= 1'b0;
      cnt        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
`ifdef BSUB_OVF_EN
      a_msb      <= 1'b0;
      b_msb      <= 1'b0;
      ovf        <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_sr <= a;
            b_sr <= b;
            br   <= 1'b0;
            cnt  <= '0;
            busy <= 1'b1;
`ifdef BSUB_OVF_EN
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
`endif
          end
        end
        SHIFT: begin
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          res  <= res_next;
          br   <= br_next;
          cnt  <= cnt + 1'b1;
          if (last_bit) begin
            busy       <= 1'b0;
            done       <= 1'b1;
            diff       <= res_next;
            borrow_out <= br_next;
`ifdef BSUB_OVF_EN
            ovf        <= (a_msb ^ b_msb) & (bit_d ^ a_msb);
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bit_serial_sub.sv
// tb/tb_bit_serial_sub.sv - scoreboard bench for bit_serial_sub against an arithmetic reference
module tb_bit_serial_sub;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         busy, done, borrow_out;
  logic [W-1:0] diff;
`ifdef BSUB_OVF_EN
  logic         ovf;
`endif

  bit_serial_sub #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .diff(diff), .borrow_out(borrow_out)
`ifdef BSUB_OVF_EN
    , .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] d;
    logic         br;
    logic         ov;
    int           due;
  } exp_t;

  exp_t         sb[$];
  int           cyc = 0;
  int           next_free = 0;
  int           acc_cyc = -1000;
  bit           rst_seen = 0;
  int           checks = 0;
  int           errors = 0;
  int           dones = 0;
  logic [W-1:0] last_d = '0;
  logic         last_br = 1'b0;
  logic         last_ov = 1'b0;

  function automatic exp_t reference(input logic [W-1:0] x, input logic [W-1:0] y, input int due);
    exp_t e;
    int   xi, yi, sx, sy, sd;
    xi = int'(x);
    yi = int'(y);
    sx = x[W-1] ? xi - (1 << W) : xi;
    sy = y[W-1] ? yi - (1 << W) : yi;
    sd = sx - sy;
    e.d   = W'(xi - yi);
    e.br  = (xi < yi);
    e.ov  = (sd > (1 << (W - 1)) - 1) || (sd < -(1 << (W - 1)));
    e.due = due;
    return e;
  endfunction

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: decides acceptance from elapsed time since the last accepted request
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      sb.delete();
      next_free = cyc + 1;
      acc_cyc   = -1000;
      rst_seen  = 1;
    end else if (start && cyc >= next_free) begin
      sb.push_back(reference(a, b, cyc + W));
      acc_cyc   = cyc;
      next_free = cyc + W + 2;
    end
  end

  // Monitor: compares outputs away from the active edge
  always @(negedge clk) begin
    if (cyc > 0) begin
      if (rst_seen) begin
        last_d   = '0;
        last_br  = 1'b0;
        last_ov  = 1'b0;
        rst_seen = 0;
      end
      if (done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          dones++;
          check("done_cycle", cyc, e.due);
          last_d  = e.d;
          last_br = e.br;
          last_ov = e.ov;
        end
      end else if (sb.size() > 0 && sb[0].due <= cyc) begin
        check("missing_done", 0, 1);
        void'(sb.pop_front());
      end
      check("busy", busy, (cyc >= acc_cyc && cyc < acc_cyc + W) ? 1 : 0);
      check("diff", diff, last_d);
      check("borrow_out", borrow_out, last_br);
`ifdef BSUB_OVF_EN
      check("ovf", ovf, last_ov);
`endif
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic pulse(input logic [W-1:0] x, input logic [W-1:0] y);
    a = x;
    b = y;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    a = $urandom;
    b = $urandom;
  endtask

  task automatic expect_literal(input string name, input logic [W-1:0] d, input logic br);
    check({name, "_diff"}, diff, d);
    check({name, "_borrow"}, borrow_out, br);
  endtask

  int d0;

  initial begin
    tick(3);
    rst = 1'b0;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_diff", diff, 0);
    tick(2);

    pulse(8'd5, 8'd3);
    tick(W + 2);
    expect_literal("t1", 8'h02, 1'b0);
    pulse(8'd3, 8'd5);
    tick(W + 2);
    expect_literal("t2a", 8'hFE, 1'b1);
    pulse(8'd0, 8'd0);
    tick(W + 2);
    expect_literal("t2b", 8'h00, 1'b0);
    pulse(8'h80, 8'h01);
    tick(W + 2);
    expect_literal("t3a", 8'h7F, 1'b0);
`ifdef BSUB_OVF_EN
    check("t3a_ovf", ovf, 1);
`endif
    pulse(8'h7F, 8'h01);
    tick(W + 2);
`ifdef BSUB_OVF_EN
    check("t3b_ovf", ovf, 0);
`endif

    d0 = dones;
    pulse(8'd9, 8'd4);
    tick(2);
    pulse(8'd1, 8'd2);
    tick(W + 4);
    expect_literal("t4", 8'h05, 1'b0);
    check("t4_single_done", dones - d0, 1);

    d0 = dones;
    a = 8'hFF;
    b = 8'h01;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(3);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("t5_busy", busy, 0);
    check("t5_diff", diff, 0);
    tick(W + 2);
    check("t5_no_done", dones - d0, 0);
    pulse(8'h10, 8'h10);
    tick(W + 2);
    expect_literal("t5b", 8'h00, 1'b0);

    d0 = dones;
    a = 8'd7;
    b = 8'd2;
    start = 1'b1;
    tick(40);
    start = 1'b0;
    tick(W + 2);
    check("t6_done_count", dones - d0, 4);
    expect_literal("t6", 8'h05, 1'b0);

    for (int i = 0; i < 300; i++) begin
      a = $urandom;
      b = $urandom;
      start = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 60) == 0);
      tick(1);
    end
    start = 1'b0;
    rst = 1'b0;

    for (int i = 0; i < 50 && sb.size() > 0; i++) tick(1);
    check("drain", sb.size(), 0);
    check("some_dones", (dones > 20) ? 1 : 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
